// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of one FIFO write port among NUM_REQ requesters; optional FIFO_WR_ARB_STATS_EN adds per-requester word counters.
// Latency: grant one cycle after req_valid, then write strobe is combinational from req_valid of the granted requester.
// Backpressure: fifo_full clears req_ready/fifo_wr_en and freezes the burst; grant is held through a stall.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stat_words
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [7:0]             burst_cnt;

    logic [DATA_WIDTH-1:0]  req_words [NUM_REQ];
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found;
    logic [IDX_W:0]         scan;
    logic                   gnt_vld;
    logic                   xfer;
    logic                   burst_end;
    logic [7:0]             burst_cnt_inc;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating priority: start one past the last winner and wrap.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        scan      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_REQ)) begin
                scan = scan - (IDX_W+1)'(NUM_REQ);
            end
            if (!sel_found && req_valid[scan[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan[IDX_W-1:0];
            end
        end
    end

    // While granted, rr_ptr names the owner, so it doubles as the data mux select.
    assign gnt_vld       = req_valid[rr_ptr];
    assign xfer          = (state == ST_GRANT) && gnt_vld && !fifo_full && !areset;
    assign burst_cnt_inc = burst_cnt + 8'd1;
    assign burst_end     = (xfer && (req_last[rr_ptr] || (burst_cnt_inc == MAX_BURST_C)))
                         || (!gnt_vld && !fifo_full);

    assign req_ready    = grant & {NUM_REQ{!fifo_full && !areset}};
    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = req_words[rr_ptr];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state     <= ST_GRANT;
                        grant     <= ONE_HOT_0 << sel_idx;
                        busy      <= 1'b1;
                        rr_ptr    <= sel_idx;
                        burst_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt_inc;
                    end
                    if (burst_end) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0] stat_cnt [NUM_REQ];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (stat_cnt[i] != 32'hFFFF_FFFF)) begin
                    stat_cnt[i] <= stat_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        assign stat_words[i*32 +: 32] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, multi-cycle scenarios, randomized run against a cycle model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic [N-1:0]      grant;
    logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*32-1:0]   stat_words;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 aclk = ~aclk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_words   (stat_words)
`endif
    );

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         f;
        logic [N-1:0] g;
        logic [N-1:0] r;
        logic         w;
    } vec_t;

    vec_t tbl [17];
    int   seq [N];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        next_cycle();
        next_cycle();
        areset = 1'b0;
    endtask

    task automatic drive_seq_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
    endtask

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] l, input logic f,
                                input logic [N-1:0] g, input logic [N-1:0] r, input logic w);
        vec_t t;
        t.v = v; t.l = l; t.f = f; t.g = g; t.r = r; t.w = w;
        return t;
    endfunction

    // Cycle-level reference model state
    int           m_own;
    int           m_rr;
    int           m_cnt;
    logic [DW-1:0] pd [N];
    logic          pl [N];
    logic          pv [N];

    initial begin
        int errs;
        int wcnt;
        int gi;
        logic [N-1:0] eg, er;
        logic         ew;

        // grant from the row's registered state; idle rows expect 0
        tbl[0]  = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tbl[1]  = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tbl[2]  = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1);
        tbl[3]  = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1);
        tbl[4]  = mk(4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1);
        tbl[5]  = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tbl[6]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tbl[7]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1);
        tbl[8]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1);
        tbl[9]  = mk(4'b1100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1);
        tbl[10] = mk(4'b1000, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0);
        tbl[11] = mk(4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tbl[12] = mk(4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b1);
        tbl[13] = mk(4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b0);
        tbl[14] = mk(4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b0);
        tbl[15] = mk(4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b0);
        tbl[16] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

        req_data = '0;
        areset   = 1'b1;
        req_valid = 4'b1111;
        req_last  = '0;
        fifo_full = 1'b0;
        @(negedge aclk);
        chk("ready_in_reset", req_ready, 4'b0000);
        chk("wr_en_in_reset", fifo_wr_en, 1'b0);
        do_reset();
        @(negedge aclk);
        chk("reset_grant", grant, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wr_en", fifo_wr_en, 1'b0);
        next_cycle();

        // Directed table
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        for (int k = 0; k < 17; k++) begin
            req_valid = tbl[k].v;
            req_last  = tbl[k].l;
            fifo_full = tbl[k].f;
            @(negedge aclk);
            chk($sformatf("vec%0d_grant", k), grant, tbl[k].g);
            chk($sformatf("vec%0d_ready", k), req_ready, tbl[k].r);
            chk($sformatf("vec%0d_wr_en", k), fifo_wr_en, tbl[k].w);
            if (tbl[k].w) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (tbl[k].g[i]) gi = i;
                chk($sformatf("vec%0d_data", k), fifo_wr_data, 32'hD000_0000 + 32'(gi));
            end
            next_cycle();
        end

        // All requesters valid, no last: 8-word bursts in round-robin order with one idle bubble
        do_reset();
        for (int i = 0; i < N; i++) seq[i] = 0;
        drive_seq_data();
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            errs = 0;
            wcnt = 0;
            for (int c = 0; c < 9; c++) begin
                @(negedge aclk);
                if (c == 0) begin
                    if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) errs++;
                end else begin
                    if (grant !== (4'b0001 << (b % 4))) errs++;
                    if (fifo_wr_en === 1'b1) begin
                        wcnt++;
                        if (fifo_wr_data !== {8'(b % 4), 24'(seq[b % 4])}) errs++;
                    end
                    seq[b % 4]++;
                end
                next_cycle();
                drive_seq_data();
            end
            chk($sformatf("rr_burst%0d_pattern", b), 32'(errs), 32'd0);
            chk($sformatf("rr_burst%0d_writes", b), 32'(wcnt), 32'd8);
        end
`ifdef FIFO_WR_ARB_STATS_EN
        chk("stat_words", stat_words, {32'd8, 32'd8, 32'd8, 32'd16});
`endif

        // Five-cycle stall after the second word of a burst
        do_reset();
        req_valid = 4'b0001;
        @(negedge aclk);
        chk("stall_arb_cycle", grant, 4'b0000);
        next_cycle();
        errs = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            if (grant !== 4'b0001 || fifo_wr_en !== 1'b1) errs++;
            next_cycle();
        end
        chk("stall_first_words", 32'(errs), 32'd0);
        fifo_full = 1'b1;
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            if (grant !== 4'b0001 || req_ready !== 4'b0000 || fifo_wr_en !== 1'b0) errs++;
            next_cycle();
        end
        chk("stall_hold", 32'(errs), 32'd0);
        fifo_full = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            if (grant === 4'b0001 && fifo_wr_en === 1'b1) wcnt++;
            next_cycle();
        end
        chk("stall_remaining_words", 32'(wcnt), 32'd6);
        @(negedge aclk);
        chk("stall_release", grant, 4'b0000);
        next_cycle();

        // Reset in the middle of a burst on requester 1
        do_reset();
        req_valid = 4'b0010;
        next_cycle();
        @(negedge aclk);
        chk("rst_mid_grant", grant, 4'b0010);
        next_cycle();
        next_cycle();
        areset = 1'b1;
        @(negedge aclk);
        chk("rst_mid_wr_en", fifo_wr_en, 1'b0);
        chk("rst_mid_ready", req_ready, 4'b0000);
        next_cycle();
        areset    = 1'b0;
        req_valid = 4'b1111;
        @(negedge aclk);
        chk("rst_after_grant", grant, 4'b0000);
        next_cycle();
        @(negedge aclk);
        chk("rst_first_winner", grant, 4'b0001);
        next_cycle();

        // Randomized traffic against the reference model
        do_reset();
        m_own = -1;
        m_rr  = N - 1;
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pl[i] = 1'b0;
            pd[i] = '0;
        end
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom_range(0, 99) < 55)) begin
                    pv[i] = 1'b1;
                    pd[i] = $urandom;
                    pl[i] = ($urandom_range(0, 3) == 0);
                end
                req_valid[i]         = pv[i];
                req_last[i]          = pl[i];
                req_data[i*DW +: DW] = pd[i];
            end
            fifo_full = ($urandom_range(0, 99) < 20);
            areset    = ($urandom_range(0, 299) == 0);
            @(negedge aclk);

            eg = '0;
            er = '0;
            ew = 1'b0;
            if (m_own >= 0) begin
                eg = 4'b0001 << m_own;
                if (!fifo_full) er = eg;
                ew = pv[m_own] && !fifo_full;
            end
            if (areset) begin
                er = '0;
                ew = 1'b0;
            end
            chk("rand_ctrl", {grant, req_ready, fifo_wr_en}, {eg, er, ew});
            if (ew) chk("rand_data", fifo_wr_data, pd[m_own]);

            if (areset) begin
                m_own = -1;
                m_rr  = N - 1;
                m_cnt = 0;
            end else if (m_own < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_own < 0 && pv[(m_rr + k) % N]) begin
                        m_own = (m_rr + k) % N;
                        m_cnt = 0;
                    end
                end
                if (m_own >= 0) m_rr = m_own;
            end else if (ew) begin
                m_cnt++;
                if (pl[m_own] || m_cnt == MB) m_own = -1;
            end else if (!pv[m_own] && !fifo_full) begin
                m_own = -1;
            end
            for (int i = 0; i < N; i++) if (pv[i] && er[i]) pv[i] = 1'b0;
            next_cycle();
        end
        areset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
